// File: rtl/regfile_wb_scheduler.sv
// Write-back scheduler for the dual-write-port register file.
// Round-robin arbitration over NREQ requesters, at most two grants per cycle,
// never two grants to the same register in one cycle. Grants are registered
// onto the WE/WE2 ports and a pending scoreboard tracks in-flight writes.
module regfile_wb_scheduler #(
    parameter int NREQ          = 3,
    parameter bit ZERO_WRITE_EN = 1'b1,
    parameter int CNT_W         = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [5*NREQ-1:0]    req_addr,
    input  logic [32*NREQ-1:0]   req_data,
    output logic [NREQ-1:0]      req_ready,
    output logic                 rf_we,
    output logic [4:0]           rf_addr,
    output logic [31:0]          rf_data,
    output logic                 rf_we2,
    output logic [4:0]           rf_addr2,
    output logic [31:0]          rf_data2,
    output logic [31:0]          pending,
    output logic [CNT_W-1:0]     conflict_cnt
);

    // Unpacked views of the flattened request buses.
    logic [4:0]  addr_arr [NREQ];
    logic [31:0] data_arr [NREQ];

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign addr_arr[gi] = req_addr[5*gi +: 5];
            assign data_arr[gi] = req_data[32*gi +: 32];
        end
    endgenerate

    // Registered state.
    logic [1:0]        rr_ptr_reg;
    logic              rf_we_reg, rf_we2_reg;
    logic [4:0]        rf_addr_reg, rf_addr2_reg;
    logic [31:0]       rf_data_reg, rf_data2_reg;
    logic [31:0]       pending_reg;
    logic [CNT_W-1:0]  conflict_cnt_reg;

    // Scan results.
    logic [NREQ-1:0]   ready_next;
    logic              a_found, b_found;
    logic [1:0]        a_idx, b_idx;
    logic              conflict_next;
    logic [1:0]        rr_ptr_next;
    logic [31:0]       set_mask, clr_mask, pending_next;

    // Round-robin grant scan starting at rr_ptr: slot A first, slot B must differ in address.
    always_comb begin
        int       pos;
        logic [1:0] idx;
        ready_next    = '0;
        a_found       = 1'b0;
        b_found       = 1'b0;
        a_idx         = 2'd0;
        b_idx         = 2'd0;
        conflict_next = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            pos = int'(rr_ptr_reg) + k;
            if (pos >= NREQ) pos = pos - NREQ;
            idx = 2'(pos);
            if (req_valid[idx]) begin
                if (!ZERO_WRITE_EN && addr_arr[idx] == 5'd0) begin
                    // Discarded write: always accepted, consumes no slot.
                    ready_next[idx] = 1'b1;
                end else if (!a_found) begin
                    a_found         = 1'b1;
                    a_idx           = idx;
                    ready_next[idx] = 1'b1;
                end else if (addr_arr[idx] == addr_arr[a_idx]) begin
                    // Held back solely by the address clash while port 2 was still free.
                    if (!b_found) conflict_next = 1'b1;
                end else if (!b_found) begin
                    b_found         = 1'b1;
                    b_idx           = idx;
                    ready_next[idx] = 1'b1;
                end
            end
        end
    end

    // Pointer advances past the last slot-granted requester; addr-0 discards do not move it.
    always_comb begin
        int nxt;
        nxt = int'(rr_ptr_reg);
        if (b_found)      nxt = int'(b_idx) + 1;
        else if (a_found) nxt = int'(a_idx) + 1;
        if (nxt >= NREQ) nxt = 0;
        rr_ptr_next = 2'(nxt);
    end

    // Scoreboard: set bits for new grants, clear bits for writes committing now; set wins.
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (a_found)    set_mask[addr_arr[a_idx]] = 1'b1;
        if (b_found)    set_mask[addr_arr[b_idx]] = 1'b1;
        if (rf_we_reg)  clr_mask[rf_addr_reg]     = 1'b1;
        if (rf_we2_reg) clr_mask[rf_addr2_reg]    = 1'b1;
        pending_next = (pending_reg & ~clr_mask) | set_mask;
    end

    // Requesters see no grant while reset is held.
    assign req_ready = rst ? '0 : ready_next;

    // Register the granted slots onto the write ports and update bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_reg       <= 2'd0;
            rf_we_reg        <= 1'b0;
            rf_we2_reg       <= 1'b0;
            rf_addr_reg      <= 5'd0;
            rf_addr2_reg     <= 5'd0;
            rf_data_reg      <= 32'd0;
            rf_data2_reg     <= 32'd0;
            pending_reg      <= 32'd0;
            conflict_cnt_reg <= '0;
        end else begin
            rr_ptr_reg  <= rr_ptr_next;
            rf_we_reg   <= a_found;
            rf_we2_reg  <= b_found;
            pending_reg <= pending_next;
            if (a_found) begin
                rf_addr_reg <= addr_arr[a_idx];
                rf_data_reg <= data_arr[a_idx];
            end
            if (b_found) begin
                rf_addr2_reg <= addr_arr[b_idx];
                rf_data2_reg <= data_arr[b_idx];
            end
            if (conflict_next && conflict_cnt_reg != {CNT_W{1'b1}})
                conflict_cnt_reg <= conflict_cnt_reg + 1'b1;
        end
    end

    assign rf_we        = rf_we_reg;
    assign rf_addr      = rf_addr_reg;
    assign rf_data      = rf_data_reg;
    assign rf_we2       = rf_we2_reg;
    assign rf_addr2     = rf_addr2_reg;
    assign rf_data2     = rf_data2_reg;
    assign pending      = pending_reg;
    assign conflict_cnt = conflict_cnt_reg;

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Directed bench for regfile_wb_scheduler: vector table plus hand sequences
// for reset, addr-0 discard and round-robin fairness.
module tb_regfile_wb_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    // Main instance (ZERO_WRITE_EN = 1)
    logic [2:0]  req_valid = '0;
    logic [14:0] req_addr  = '0;
    logic [95:0] req_data  = '0;
    logic [2:0]  req_ready;
    logic        rf_we, rf_we2;
    logic [4:0]  rf_addr, rf_addr2;
    logic [31:0] rf_data, rf_data2;
    logic [31:0] pending;
    logic [15:0] conflict_cnt;

    // Instance with register-0 writes discarded
    logic [2:0]  z_valid = '0;
    logic [14:0] z_addr  = '0;
    logic [95:0] z_data  = '0;
    logic [2:0]  z_ready;
    logic        z_we, z_we2;
    logic [4:0]  z_addr1, z_addr2;
    logic [31:0] z_data1, z_data2;
    logic [31:0] z_pending;
    logic [15:0] z_cnt;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    regfile_wb_scheduler #(.NREQ(3), .ZERO_WRITE_EN(1'b1), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
        .req_ready(req_ready),
        .rf_we(rf_we), .rf_addr(rf_addr), .rf_data(rf_data),
        .rf_we2(rf_we2), .rf_addr2(rf_addr2), .rf_data2(rf_data2),
        .pending(pending), .conflict_cnt(conflict_cnt)
    );

    regfile_wb_scheduler #(.NREQ(3), .ZERO_WRITE_EN(1'b0), .CNT_W(16)) u_dut_z (
        .clk(clk), .rst(rst),
        .req_valid(z_valid), .req_addr(z_addr), .req_data(z_data),
        .req_ready(z_ready),
        .rf_we(z_we), .rf_addr(z_addr1), .rf_data(z_data1),
        .rf_we2(z_we2), .rf_addr2(z_addr2), .rf_data2(z_data2),
        .pending(z_pending), .conflict_cnt(z_cnt)
    );

    typedef struct {
        logic [2:0]  valid;
        logic [4:0]  a0, a1, a2;
        logic [31:0] d0, d1, d2;
        logic [2:0]  ready;
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
        logic        we2;
        logic [4:0]  addr2;
        logic [31:0] data2;
        logic [31:0] pend;
        logic [15:0] cnt;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [2:0] v, input logic [4:0] a0, a1, a2,
                         input logic [31:0] d0, d1, d2);
        req_valid = v;
        req_addr  = {a2, a1, a0};
        req_data  = {d2, d1, d0};
    endtask

    int gcnt [3];

    initial begin
        // Columns: valid, a0,a1,a2, d0,d1,d2 | ready, we,addr,data, we2,addr2,data2, pending, conflict_cnt
        vecs[0] = '{3'b111, 5'd5, 5'd6, 5'd7, 32'h105, 32'h106, 32'h107,
                    3'b011, 1'b1, 5'd5, 32'h105, 1'b1, 5'd6, 32'h106, 32'h0000_0060, 16'd0};
        vecs[1] = '{3'b100, 5'd5, 5'd6, 5'd7, 32'h105, 32'h106, 32'h107,
                    3'b100, 1'b1, 5'd7, 32'h107, 1'b0, 5'd6, 32'h106, 32'h0000_0080, 16'd0};
        vecs[2] = '{3'b011, 5'd9, 5'd9, 5'd7, 32'hAAAA, 32'h5555, 32'h107,
                    3'b001, 1'b1, 5'd9, 32'hAAAA, 1'b0, 5'd6, 32'h106, 32'h0000_0200, 16'd1};
        vecs[3] = '{3'b010, 5'd9, 5'd9, 5'd7, 32'hAAAA, 32'h5555, 32'h107,
                    3'b010, 1'b1, 5'd9, 32'h5555, 1'b0, 5'd6, 32'h106, 32'h0000_0200, 16'd1};
        vecs[4] = '{3'b001, 5'd12, 5'd9, 5'd7, 32'hC, 32'h5555, 32'h107,
                    3'b001, 1'b1, 5'd12, 32'hC, 1'b0, 5'd6, 32'h106, 32'h0000_1000, 16'd1};
        vecs[5] = '{3'b001, 5'd12, 5'd9, 5'd7, 32'hD, 32'h5555, 32'h107,
                    3'b001, 1'b1, 5'd12, 32'hD, 1'b0, 5'd6, 32'h106, 32'h0000_1000, 16'd1};
        vecs[6] = '{3'b000, 5'd12, 5'd9, 5'd7, 32'hD, 32'h5555, 32'h107,
                    3'b000, 1'b0, 5'd12, 32'hD, 1'b0, 5'd6, 32'h106, 32'h0000_0000, 16'd1};
        vecs[7] = '{3'b111, 5'd4, 5'd3, 5'd3, 32'h1, 32'h2, 32'h3,
                    3'b011, 1'b1, 5'd3, 32'h2, 1'b1, 5'd4, 32'h1, 32'h0000_0018, 16'd2};
        vecs[8] = '{3'b100, 5'd4, 5'd3, 5'd3, 32'h1, 32'h2, 32'h3,
                    3'b100, 1'b1, 5'd3, 32'h3, 1'b0, 5'd4, 32'h1, 32'h0000_0008, 16'd2};
        vecs[9] = '{3'b000, 5'd4, 5'd3, 5'd3, 32'h1, 32'h2, 32'h3,
                    3'b000, 1'b0, 5'd3, 32'h3, 1'b0, 5'd4, 32'h1, 32'h0000_0000, 16'd2};

        // Reset state
        #12;
        chk("rst_we",      64'(rf_we),        64'd0);
        chk("rst_we2",     64'(rf_we2),       64'd0);
        chk("rst_addr",    64'(rf_addr),      64'd0);
        chk("rst_data",    64'(rf_data),      64'd0);
        chk("rst_pending", 64'(pending),      64'd0);
        chk("rst_cnt",     64'(conflict_cnt), 64'd0);
        chk("rst_ready",   64'(req_ready),    64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Register-0 discard on the ZERO_WRITE_EN=0 instance
        @(negedge clk);
        z_valid = 3'b011;
        z_addr  = {5'd0, 5'd3, 5'd0};
        z_data  = {32'h0, 32'h33, 32'hDEAD};
        #1;
        chk("z_ready_both", 64'(z_ready), 64'b011);
        @(posedge clk); #1;
        chk("z_we",      64'(z_we),      64'd1);
        chk("z_addr",    64'(z_addr1),   64'd3);
        chk("z_data",    64'(z_data1),   64'h33);
        chk("z_we2",     64'(z_we2),     64'd0);
        chk("z_pending", 64'(z_pending), 64'h8);
        @(negedge clk);
        z_valid = 3'b001;
        #1;
        chk("z_ready_zero", 64'(z_ready), 64'b001);
        @(posedge clk); #1;
        chk("z_we_zero",   64'(z_we),      64'd0);
        chk("z_pend_zero", 64'(z_pending), 64'h0);
        @(negedge clk);
        z_valid = 3'b000;

        // Vector table: one cycle per entry on the main instance
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            drive(vecs[i].valid, vecs[i].a0, vecs[i].a1, vecs[i].a2,
                  vecs[i].d0, vecs[i].d1, vecs[i].d2);
            #1;
            chk($sformatf("v%0d_ready", i), 64'(req_ready), 64'(vecs[i].ready));
            @(posedge clk); #1;
            chk($sformatf("v%0d_we", i),    64'(rf_we),        64'(vecs[i].we));
            chk($sformatf("v%0d_addr", i),  64'(rf_addr),      64'(vecs[i].addr));
            chk($sformatf("v%0d_data", i),  64'(rf_data),      64'(vecs[i].data));
            chk($sformatf("v%0d_we2", i),   64'(rf_we2),       64'(vecs[i].we2));
            chk($sformatf("v%0d_addr2", i), 64'(rf_addr2),     64'(vecs[i].addr2));
            chk($sformatf("v%0d_data2", i), 64'(rf_data2),     64'(vecs[i].data2));
            chk($sformatf("v%0d_pend", i),  64'(pending),      64'(vecs[i].pend));
            chk($sformatf("v%0d_cnt", i),   64'(conflict_cnt), 64'(vecs[i].cnt));
            $display("[TB] vec %0d valid=%b ready=%b we=%b/%b pending=%h cnt=%0d",
                     i, req_valid, req_ready, rf_we, rf_we2, pending, conflict_cnt);
        end

        // Mid-stream asynchronous reset with every requester valid
        @(negedge clk);
        drive(3'b111, 5'd10, 5'd11, 5'd12, 32'h10, 32'h11, 32'h12);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_we",    64'(rf_we),        64'd0);
        chk("mid_rst_we2",   64'(rf_we2),       64'd0);
        chk("mid_rst_addr",  64'(rf_addr),      64'd0);
        chk("mid_rst_data2", 64'(rf_data2),     64'd0);
        chk("mid_rst_pend",  64'(pending),      64'd0);
        chk("mid_rst_cnt",   64'(conflict_cnt), 64'd0);
        chk("mid_rst_ready", 64'(req_ready),    64'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("first_grant_req0", 64'(req_ready), 64'b011);

        // Fairness: 30 cycles with all requesters valid, distinct addresses
        for (int i = 0; i < 3; i++) gcnt[i] = 0;
        for (int c = 0; c < 30; c++) begin
            if (c > 0) begin
                @(negedge clk);
                #1;
            end
            for (int i = 0; i < 3; i++) if (req_ready[i]) gcnt[i]++;
        end
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("fair_req%0d", i), 64'(gcnt[i]), 64'd20);
            $display("[TB] fairness req%0d grants=%0d", i, gcnt[i]);
        end
        @(negedge clk);
        drive(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
